// File: rtl/err_scrub_ctrl_if.sv
// Bus bundle for err_scrub_ctrl: error flags and scrub handshake in,
// resync requests and status out.
interface err_scrub_ctrl_if #(
   parameter int N_SRC = 4,
   parameter int CNT_W = 8
);
   logic [N_SRC-1:0] err_i;
   logic             scrub_en_i;
   logic             scrub_ack_i;
   logic             clr_i;
   logic [N_SRC-1:0] scrub_o;
   logic [N_SRC-1:0] pending_o;
   logic [CNT_W-1:0] err_cnt_o;
   logic             fail_o;
   logic             busy_o;
   logic             err_o;

   modport master (
      output err_i, scrub_en_i, scrub_ack_i, clr_i,
      input  scrub_o, pending_o, err_cnt_o, fail_o, busy_o, err_o
   );

   modport slave (
      input  err_i, scrub_en_i, scrub_ack_i, clr_i,
      output scrub_o, pending_o, err_cnt_o, fail_o, busy_o, err_o
   );
endinterface

// File: rtl/err_scrub_ctrl.sv
// Error scrub controller: latches per-instance error flags, grants resync
// requests round-robin one at a time, and tracks event count and timeouts.
module err_scrub_ctrl #(
   parameter int N_SRC   = 4,
   parameter int CNT_W   = 8,
   parameter int TMO_CYC = 15
) (
   input  logic          clk_i,
   input  logic          rst_i,
   err_scrub_ctrl_if.slave bus
);
   localparam int IDX_W = $clog2(N_SRC);
   localparam int SW    = IDX_W + 1;
   localparam int TMO_W = $clog2(TMO_CYC + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCRUB = 2'd1,
      ST_COOL  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [N_SRC-1:0] pending_q, pending_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fail_q, fail_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [IDX_W-1:0] grant_q, grant_d;

   logic [N_SRC-1:0] grant_oh;
   logic [N_SRC-1:0] ack_mask;
   logic [N_SRC-1:0] rise;
   logic [IDX_W-1:0] sel_idx;
   logic             sel_vld;
   logic             ack_clr;
   logic             timeout;

   genvar gi;
   generate
      for (gi = 0; gi < N_SRC; gi++) begin : g_bit
         assign grant_oh[gi] = (grant_q == IDX_W'(gi));
         assign ack_mask[gi] = ack_clr & grant_oh[gi];
         // Set wins over the ack clear when both hit the same bit.
         assign pending_d[gi] = (pending_q[gi] & ~ack_mask[gi]) | bus.err_i[gi];
         assign rise[gi]      = pending_d[gi] & ~pending_q[gi];
      end
   endgenerate

   // Round-robin search starting just above the last served instance.
   always_comb begin
      logic [SW-1:0] pos;
      pos     = '0;
      sel_idx = '0;
      sel_vld = 1'b0;
      for (int k = 0; k < N_SRC; k++) begin
         pos = {1'b0, last_q} + SW'(k + 1);
         if (pos >= SW'(N_SRC)) begin
            pos = pos - SW'(N_SRC);
         end
         if (!sel_vld && pending_q[pos[IDX_W-1:0]]) begin
            sel_vld = 1'b1;
            sel_idx = pos[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      tmo_d   = tmo_q;
      ack_clr = 1'b0;
      timeout = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.scrub_en_i && sel_vld) begin
               state_d = ST_SCRUB;
               grant_d = sel_idx;
               tmo_d   = '0;
            end
         end
         ST_SCRUB: begin
            tmo_d = tmo_q + TMO_W'(1);
            if (bus.scrub_ack_i) begin
               ack_clr = 1'b1;
               last_d  = grant_q;
               state_d = ST_COOL;
            end else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
               timeout = 1'b1;
               last_d  = grant_q;
               state_d = ST_COOL;
            end
         end
         ST_COOL: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q;
      fail_d = fail_q;
      if (bus.clr_i) begin
         cnt_d  = '0;
         fail_d = 1'b0;
      end else begin
         if ((|rise) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         if (timeout) begin
            fail_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
         cnt_q     <= '0;
         fail_q    <= 1'b0;
         tmo_q     <= '0;
         last_q    <= IDX_W'(N_SRC - 1);
         grant_q   <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         fail_q    <= fail_d;
         tmo_q     <= tmo_d;
         last_q    <= last_d;
         grant_q   <= grant_d;
      end
   end

   assign bus.scrub_o   = (state_q == ST_SCRUB) ? grant_oh : '0;
   assign bus.pending_o = pending_q;
   assign bus.err_cnt_o = cnt_q;
   assign bus.fail_o    = fail_q;
   assign bus.busy_o    = (state_q != ST_IDLE);
   assign bus.err_o     = (|pending_q) | fail_q;
endmodule

// File: tb/tb_err_scrub_ctrl.sv
// Directed self-checking bench for err_scrub_ctrl (N_SRC=4, CNT_W=8, TMO_CYC=15).
module tb_err_scrub_ctrl;
   localparam int N_SRC   = 4;
   localparam int CNT_W   = 8;
   localparam int TMO_CYC = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_seen;
   logic [3:0] exp_seq [9];

   err_scrub_ctrl_if #(.N_SRC(N_SRC), .CNT_W(CNT_W)) bus ();

   err_scrub_ctrl #(.N_SRC(N_SRC), .CNT_W(CNT_W), .TMO_CYC(TMO_CYC)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   initial begin
      bus.err_i       = '0;
      bus.scrub_en_i  = 1'b0;
      bus.scrub_ack_i = 1'b0;
      bus.clr_i       = 1'b0;
      exp_seq = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000,
                  4'b1000, 4'b0000, 4'b0000};

      // Reset state
      #3;
      chk("rst_scrub",   32'(bus.scrub_o),   32'h0);
      chk("rst_pending", 32'(bus.pending_o), 32'h0);
      chk("rst_cnt",     32'(bus.err_cnt_o), 32'h0);
      chk("rst_fail",    32'(bus.fail_o),    32'h0);
      chk("rst_busy",    32'(bus.busy_o),    32'h0);
      chk("rst_err",     32'(bus.err_o),     32'h0);
      tick();
      rst = 1'b0;
      tick();

      // Single error on instance 2, ack three cycles after scrub_o
      bus.scrub_en_i = 1'b1;
      bus.err_i = 4'b0100;
      tick();
      bus.err_i = 4'b0000;
      chk("s1_pending", 32'(bus.pending_o), 32'h4);
      chk("s1_scrub0",  32'(bus.scrub_o),   32'h0);
      chk("s1_err",     32'(bus.err_o),     32'h1);
      chk("s1_cnt",     32'(bus.err_cnt_o), 32'h1);
      tick();
      chk("s1_scrub",   32'(bus.scrub_o),   32'h4);
      chk("s1_busy",    32'(bus.busy_o),    32'h1);
      tick();
      tick();
      chk("s1_hold",    32'(bus.scrub_o),   32'h4);
      bus.scrub_ack_i = 1'b1;
      tick();
      bus.scrub_ack_i = 1'b0;
      chk("s1_cool_scr", 32'(bus.scrub_o),   32'h0);
      chk("s1_cool_bsy", 32'(bus.busy_o),    32'h1);
      chk("s1_clr_pend", 32'(bus.pending_o), 32'h0);
      tick();
      chk("s1_idle",    32'(bus.busy_o),    32'h0);
      chk("s1_err_lo",  32'(bus.err_o),     32'h0);
      chk("s1_cnt_end", 32'(bus.err_cnt_o), 32'h1);

      // Fresh reset, then three simultaneous errors served 0,1,3
      rst = 1'b1;
      #2;
      rst = 1'b0;
      bus.err_i = 4'b1011;
      tick();
      bus.err_i = 4'b0000;
      bus.scrub_ack_i = 1'b1;
      chk("s2_pending", 32'(bus.pending_o), 32'hB);
      for (int i = 0; i < 9; i++) begin
         tick();
         chk($sformatf("s2_seq%0d", i), 32'(bus.scrub_o), 32'(exp_seq[i]));
      end
      chk("s2_cnt",     32'(bus.err_cnt_o), 32'h1);
      chk("s2_pend0",   32'(bus.pending_o), 32'h0);
      bus.scrub_ack_i = 1'b0;

      // Timeout on instance 1, re-grant, then clear
      bus.err_i = 4'b0010;
      tick();
      bus.err_i = 4'b0000;
      chk("s3_cnt",     32'(bus.err_cnt_o), 32'h2);
      tick();
      n_seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.scrub_o != 4'b0010) break;
         n_seen++;
         tick();
      end
      chk("s3_tmo_len", 32'(n_seen),        32'(TMO_CYC));
      chk("s3_fail",    32'(bus.fail_o),    32'h1);
      chk("s3_pending", 32'(bus.pending_o), 32'h2);
      chk("s3_err",     32'(bus.err_o),     32'h1);
      chk("s3_cool",    32'(bus.busy_o),    32'h1);
      tick();
      tick();
      chk("s3_regrant", 32'(bus.scrub_o),   32'h2);
      bus.clr_i = 1'b1;
      tick();
      bus.clr_i = 1'b0;
      chk("s3_clr_fail", 32'(bus.fail_o),    32'h0);
      chk("s3_clr_cnt",  32'(bus.err_cnt_o), 32'h0);
      chk("s3_clr_pend", 32'(bus.pending_o), 32'h2);
      bus.scrub_ack_i = 1'b1;
      tick();
      bus.scrub_ack_i = 1'b0;
      chk("s3_ack_pend", 32'(bus.pending_o), 32'h0);
      tick();

      // Error on instance 2 coincident with its ack: set wins
      bus.err_i = 4'b0100;
      tick();
      bus.err_i = 4'b0000;
      chk("s4_cnt1",    32'(bus.err_cnt_o), 32'h1);
      tick();
      chk("s4_scrub",   32'(bus.scrub_o),   32'h4);
      bus.err_i = 4'b0100;
      bus.scrub_ack_i = 1'b1;
      tick();
      bus.err_i = 4'b0000;
      bus.scrub_ack_i = 1'b0;
      chk("s4_pending", 32'(bus.pending_o), 32'h4);
      chk("s4_cnt",     32'(bus.err_cnt_o), 32'h1);
      tick();
      tick();
      chk("s4_regrant", 32'(bus.scrub_o),   32'h4);
      bus.scrub_ack_i = 1'b1;
      tick();
      bus.scrub_ack_i = 1'b0;
      tick();

      // Counter saturation and clear-wins
      bus.clr_i = 1'b1;
      tick();
      bus.clr_i = 1'b0;
      bus.scrub_ack_i = 1'b1;
      for (int i = 0; i < 256; i++) begin
         bus.err_i = 4'b0001;
         tick();
         bus.err_i = 4'b0000;
         repeat (4) tick();
         if (i == 254) chk("s5_cnt255", 32'(bus.err_cnt_o), 32'd255);
      end
      chk("s5_sat",     32'(bus.err_cnt_o), 32'd255);
      chk("s5_idle",    32'(bus.busy_o),    32'h0);
      bus.err_i = 4'b0001;
      bus.clr_i = 1'b1;
      tick();
      bus.err_i = 4'b0000;
      bus.clr_i = 1'b0;
      chk("s5_clr",     32'(bus.err_cnt_o), 32'h0);
      repeat (4) tick();
      bus.scrub_ack_i = 1'b0;

      // Asynchronous reset mid-scrub
      bus.err_i = 4'b1000;
      tick();
      bus.err_i = 4'b0000;
      tick();
      chk("s6_scrub",   32'(bus.scrub_o),   32'h8);
      #2;
      rst = 1'b1;
      #1;
      chk("s6_rst_scr", 32'(bus.scrub_o),   32'h0);
      chk("s6_rst_pnd", 32'(bus.pending_o), 32'h0);
      chk("s6_rst_bsy", 32'(bus.busy_o),    32'h0);
      #1;
      rst = 1'b0;
      tick();
      bus.err_i = 4'b0011;
      tick();
      bus.err_i = 4'b0000;
      chk("s6_pending", 32'(bus.pending_o), 32'h3);
      tick();
      chk("s6_grant0",  32'(bus.scrub_o),   32'h1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
